// File: rtl/datapath_controller_if.sv
// Bundles the instruction handshake and the datapath control outputs of datapath_controller.
// The controller uses the slave modport; the instruction source/observer uses master.
interface datapath_controller_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] regEnable;
  logic [3:0]  a_select;
  logic [3:0]  b_select;
  logic        use_imm;
  logic [15:0] immediate;
  logic [7:0]  opCode;
  logic        busy;
  logic        retired;

  modport master (
    output instr, instr_valid,
    input  instr_ready, regEnable, a_select, b_select, use_imm,
           immediate, opCode, busy, retired
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, regEnable, a_select, b_select, use_imm,
           immediate, opCode, busy, retired
  );
endinterface

// File: rtl/datapath_controller.sv
// Multi-cycle FETCH/DECODE/SETTLE/EXEC sequencer driving register-file/ALU controls.
// Optional macro DPCTRL_PERF_CNT_EN adds a 16-bit wrapping retired_count output.
module datapath_controller #(
  parameter int WB_DELAY     = 0,
  parameter bit IMM_SIGN_EXT = 1'b1
) (
  input  logic clk,
  input  logic reset,
`ifdef DPCTRL_PERF_CNT_EN
  output logic [15:0] retired_count,
`endif
  datapath_controller_if.slave bus
);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_SETTLE, S_EXEC} state_t;

  localparam logic [3:0] LP_LAST = (WB_DELAY > 0) ? 4'(WB_DELAY - 1) : 4'd0;

  state_t      r_state;
  logic [15:0] r_ir;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic        r_busy;
  logic        r_retired;
  logic        r_use_imm;
  logic [15:0] r_regen;
  logic [15:0] r_imm;
  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic [7:0]  r_op;

  logic [3:0]  w_op;
  logic [3:0]  w_ext;
  logic [3:0]  w_rs;
  logic [15:0] w_imm_ext;
  logic [15:0] w_onehot;
  logic        w_nowrite;
  logic        w_go_exec;

  assign w_op      = bus.instr[15:12];
  assign w_ext     = bus.instr[7:4];
  assign w_rs      = bus.instr[3:0];
  assign w_imm_ext = IMM_SIGN_EXT ? {{8{bus.instr[7]}}, bus.instr[7:0]}
                                  : {8'h00, bus.instr[7:0]};

  // NOP, CMP and CMPI only update flags; they retire without a register write.
  assign w_nowrite = (r_ir == 16'h0000)
                   || ((r_ir[15:12] == 4'h0) && (r_ir[7:4] == 4'hB))
                   || (r_ir[15:12] == 4'hB);

  assign w_go_exec = ((r_state == S_DECODE) && (WB_DELAY == 0))
                   || ((r_state == S_SETTLE) && (r_cnt == LP_LAST));

  for (genvar gi = 0; gi < 16; gi++) begin : g_onehot
    assign w_onehot[gi] = (r_ir[11:8] == 4'(gi));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_retired <= 1'b0;
      r_use_imm <= 1'b0;
      r_regen   <= '0;
      r_imm     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
    end else begin
      r_regen   <= '0;
      r_retired <= 1'b0;
      case (r_state)
        S_FETCH: begin
          r_ready <= 1'b1;
          // Decoded controls are loaded on the accept edge so they are valid in DECODE.
          if (r_ready && bus.instr_valid) begin
            r_ir    <= bus.instr;
            r_state <= S_DECODE;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_a     <= bus.instr[11:8];
            if (w_op == 4'h0) begin
              r_b       <= w_rs;
              r_use_imm <= 1'b0;
              r_op      <= {4'h0, w_ext};
            end else begin
              r_b       <= 4'h0;
              r_use_imm <= 1'b1;
              r_op      <= {w_op, 4'h0};
              r_imm     <= w_imm_ext;
            end
          end
        end
        S_DECODE: begin
          r_cnt <= '0;
          if (!w_go_exec) r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (!w_go_exec) r_cnt <= r_cnt + 4'd1;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= S_FETCH;
      endcase
      if (w_go_exec) begin
        r_state   <= S_EXEC;
        r_retired <= 1'b1;
        r_regen   <= w_nowrite ? 16'h0000 : w_onehot;
      end
    end
  end

`ifdef DPCTRL_PERF_CNT_EN
  logic [15:0] r_retired_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_retired_count <= '0;
    else if (w_go_exec) r_retired_count <= r_retired_count + 16'd1;
  end

  assign retired_count = r_retired_count;
`endif

  assign bus.instr_ready = r_ready;
  assign bus.regEnable   = r_regen;
  assign bus.a_select    = r_a;
  assign bus.b_select    = r_b;
  assign bus.use_imm     = r_use_imm;
  assign bus.immediate   = r_imm;
  assign bus.opCode      = r_op;
  assign bus.busy        = r_busy;
  assign bus.retired     = r_retired;

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
- Multi-cycle control sequencer that drives the register-file/ALU datapath's control inputs: regEnable, a_select, b_select, use_imm, immediate and opCode.
- Accepts 16-bit instructions over a valid/ready handshake and decodes each one into datapath controls.
- Sequences each instruction as fetch, decode, optional settle, then a single-cycle register write-back.
- Sits between the instruction source (memory/fetch unit) and the datapath.

Parameters:
- WB_DELAY, 0, number of extra settle cycles between DECODE and EXEC (0..15); gives the ALU/flags path time to settle.
- IMM_SIGN_EXT, 1, 1 = sign-extend the 8-bit immediate to 16 bits; 0 = zero-extend.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  16  instruction word: [15:12] op, [11:8] Rdest, [7:4] ext/immHi, [3:0] Rsrc/immLo.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  controller can accept an instruction.
- regEnable  out  16  one-hot register write enable to the datapath.
- a_select  out  4  A-operand register select.
- b_select  out  4  B-operand register select.
- use_imm  out  1  1 = the ALU B operand is immediate.
- immediate  out  16  extended immediate.
- opCode  out  8  ALU opcode.
- busy  out  1  high whenever the state is not FETCH.
- retired  out  1  one-cycle pulse when an instruction completes its EXEC cycle.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset). All outputs are registered.
- Reset (reset=0): state=FETCH; IR=0; settle counter=0; regEnable, a_select, b_select, use_imm, immediate, opCode, busy and retired all 0.
- Reset effect on outputs: regEnable drops to 0 asynchronously, including when reset is asserted mid-instruction; the in-flight instruction is discarded and never written back.
- Reset effect on instr_ready: instr_ready=0 while reset is asserted; it goes to 1 on the first clock edge after release.
- States: FETCH, DECODE, SETTLE, EXEC.
- FETCH:
  - instr_ready=1, regEnable=0; all other control outputs hold their last values.
  - On an edge with instr_valid=1, latch instr into IR and go to DECODE.
  - With instr_valid=0, stay in FETCH.
- DECODE: drive the selects, use_imm, immediate and opCode from IR; regEnable=0, instr_ready=0. Go to SETTLE if WB_DELAY>0, else to EXEC.
- SETTLE: hold all decoded outputs stable; count WB_DELAY cycles, then go to EXEC.
- EXEC:
  - regEnable = 1<<Rdest for exactly one cycle, unless the instruction is no-write.
  - retired=1 for this cycle.
  - Next state is FETCH.
- Decode, R-type (op==4'h0):
  - a_select=Rdest, b_select=Rsrc, use_imm=0.
  - opCode={4'h0, ext}; immediate holds its previous value.
- Decode, I-type (op!=0):
  - a_select=Rdest, b_select=4'h0, use_imm=1.
  - opCode={op, 4'h0}; immediate=ext({ext, Rsrc}), extended per IMM_SIGN_EXT.
- No-write instructions: instr==16'h0000 (NOP), R-type with ext==4'hB (CMP), I-type with op==4'hB (CMPI). For these, regEnable stays 0 in EXEC, but retired still pulses.
- Other encodings: all other encodings, including unused ones, are passed through and do write back.
- Register 0: Rdest=0 is a legal write target; r0 is not hardwired.
- Latency:
  - Instruction accepted at edge N → DECODE in cycle N+1 → EXEC in cycle N+2+WB_DELAY.
  - instr_ready returns to 1 in cycle N+3+WB_DELAY.
  - Throughput: one instruction per 3+WB_DELAY cycles.
- Stability: selects, use_imm and opCode are stable from DECODE through EXEC, so the flags register captures the EXEC-cycle result.
- instr_valid outside FETCH: ignored, since instr_ready=0 there; the source must hold instr until the handshake completes.

Optional Feature:
- Macro: DPCTRL_PERF_CNT_EN.
- When defined: adds output port retired_count (16 bits), reset to 0, incremented on every retired pulse and wrapping from 16'hFFFF to 0. NOP and CMP instructions are counted.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset handshake: hold reset=0, then release → all outputs 0 during reset; instr_ready=1 one edge after release; busy=0.
- ADD R3,R5 (instr=16'h0355, WB_DELAY=0) → DECODE: a_select=3, b_select=5, use_imm=0, opCode=8'h05; EXEC: regEnable=16'h0008 for one cycle and retired=1; instr_ready high again 3 cycles after accept.
- ADDI R2,#-1 with IMM_SIGN_EXT=1 (instr=16'h52FF) → immediate=16'hFFFF, use_imm=1, opCode=8'h50, regEnable=16'h0004. With IMM_SIGN_EXT=0 → immediate=16'h00FF.
- CMP R1,R2 (16'h01B2) and NOP (16'h0000) → regEnable stays 0 in every cycle; retired pulses once for each.
- WB_DELAY=3 with instr_valid held high continuously → EXEC occurs 5 cycles after accept; instructions are accepted every 6 cycles; selects are constant through the SETTLE cycles.
- Assert reset during SETTLE → regEnable=0 immediately with no write-back; state returns to FETCH; with DPCTRL_PERF_CNT_EN defined, retired_count=0.
